spi_slave_ctrl: RTL

// - SPI target (slave) endpoint: the far end of the SPI controller's wire protocol, for loopback benches and SoC-to-SoC links.
// - Samples SCLK/CSN/SDI in the HCLK domain (oversampled).
// - Decodes an 8-bit command; moves 32-bit data words to/from valid/ready streams that feed the existing spi_fifo.
// - Mode 0 only (CPOL=0, CPHA=0); MSB first; std on sdi0/sdo1, quad on io[3:0].

---
 rtl/spi_slave_ctrl_if.sv | 37 +++
 rtl/spi_slave_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_ctrl_if.sv
// spi_slave_ctrl_if - SPI pad pins, rx/tx word streams and status of the SPI target.
interface spi_slave_ctrl_if;
  logic        spi_sclk;
  logic        spi_csn;
  logic        spi_sdi0, spi_sdi1, spi_sdi2, spi_sdi3;
  logic        spi_sdo0, spi_sdo1, spi_sdo2, spi_sdo3;
  logic        spi_oe0, spi_oe1, spi_oe2, spi_oe3;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  cmd_o;
  logic        busy_o;
  logic        eot_o;
  logic        ovf_o;
  logic        udf_o;

  modport slave (
    input  spi_sclk, spi_csn, spi_sdi0, spi_sdi1, spi_sdi2, spi_sdi3,
    output spi_sdo0, spi_sdo1, spi_sdo2, spi_sdo3,
    output spi_oe0, spi_oe1, spi_oe2, spi_oe3,
    output rx_data, rx_valid, input rx_ready,
    input  tx_data, tx_valid, output tx_ready,
    output cmd_o, busy_o, eot_o, ovf_o, udf_o
  );

  modport master (
    output spi_sclk, spi_csn, spi_sdi0, spi_sdi1, spi_sdi2, spi_sdi3,
    input  spi_sdo0, spi_sdo1, spi_sdo2, spi_sdo3,
    input  spi_oe0, spi_oe1, spi_oe2, spi_oe3,
    input  rx_data, rx_valid, output rx_ready,
    output tx_data, tx_valid, input tx_ready,
    input  cmd_o, busy_o, eot_o, ovf_o, udf_o
  );
endinterface

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl - SPI mode-0 target, oversampled in the HCLK domain.
// Commands: 0x02 std write, 0x0B std read (dummy cycles), 0x9F read ID.
// Define SPI_SLV_QUAD_EN to add 0x32 quad write and 0x6B quad read;
// without it those opcodes are ignored and lanes 0/2/3 are tied low.
module spi_slave_ctrl #(
  parameter int          DUMMY_CYCLES = 8,
  parameter logic [31:0] ID_VALUE     = 32'h5350_4901,
  parameter int          SYNC_STAGES  = 2
) (
  input logic             HCLK,
  input logic             HRESETn,
  spi_slave_ctrl_if.slave bus
);

`ifdef SPI_SLV_QUAD_EN
  localparam int PW = 6;
`else
  localparam int PW = 3;
`endif
  // csn idles high so reset must not fabricate a chip-select edge
  localparam logic [PW-1:0] SYNC_RST = PW'(2);

  typedef enum logic [3:0] {
    IDLE, CMD, WR_STD, WR_QUAD, DUMMY, RD_STD, RD_QUAD, RD_ID, IGNORE
  } state_t;

  logic [PW-1:0] pins;
  logic [PW-1:0] sync_r [SYNC_STAGES];
  logic [PW-1:0] synced;
  logic [1:0]    prev_r;
  logic          sclk_s, csn_s, sdi0_s;
  logic          sclk_rise, sclk_fall, csn_rise, csn_fall;
  logic [31:0]   rx_word_std;
  logic [31:0]   tx_word;

  state_t        state_r;
  logic [31:0]   shift_r;
  logic [4:0]    bit_cnt_r;
  logic [15:0]   dummy_cnt_r;
  logic          armed_r;
  logic [7:0]    cmd_r;
  logic [31:0]   rx_hold_r;
  logic          rx_valid_r;
  logic          ovf_r;
  logic          udf_r;
  logic          tx_ready_r;
  logic          eot_r;
  logic          busy_r;
  logic          oe_std_r;
`ifdef SPI_SLV_QUAD_EN
  logic          oe_quad_r;
  logic [3:0]    sdi_q_s;
  logic [31:0]   rx_word_quad;
`endif

`ifdef SPI_SLV_QUAD_EN
  assign pins = {bus.spi_sdi3, bus.spi_sdi2, bus.spi_sdi1, bus.spi_sdi0, bus.spi_csn, bus.spi_sclk};
`else
  assign pins = {bus.spi_sdi0, bus.spi_csn, bus.spi_sclk};
`endif

  // Synchronizer chain for the pad inputs plus previous-sample flops for edge detect.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= SYNC_RST;
      prev_r <= 2'b10;
    end else begin
      sync_r[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      prev_r <= sync_r[SYNC_STAGES-1][1:0];
    end
  end

  assign synced    = sync_r[SYNC_STAGES-1];
  assign sclk_s    = synced[0];
  assign csn_s     = synced[1];
  assign sdi0_s    = synced[2];
  assign sclk_rise = sclk_s & ~prev_r[0];
  assign sclk_fall = ~sclk_s & prev_r[0];
  assign csn_fall  = ~csn_s & prev_r[1];
  assign csn_rise  = csn_s & ~prev_r[1];

  assign rx_word_std = {shift_r[30:0], sdi0_s};
  // An empty tx stream sends zeros (flagged as underrun by the FSM)
  assign tx_word     = bus.tx_valid ? bus.tx_data : 32'h0000_0000;
`ifdef SPI_SLV_QUAD_EN
  assign sdi_q_s      = synced[5:2];
  assign rx_word_quad = {shift_r[27:0], sdi_q_s};
`endif

  // Control FSM: command decode, shift datapath, stream handshakes and sticky status.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r     <= IDLE;
      shift_r     <= 32'h0000_0000;
      bit_cnt_r   <= 5'd0;
      dummy_cnt_r <= 16'd0;
      armed_r     <= 1'b0;
      cmd_r       <= 8'h00;
      rx_hold_r   <= 32'h0000_0000;
      rx_valid_r  <= 1'b0;
      ovf_r       <= 1'b0;
      udf_r       <= 1'b0;
      tx_ready_r  <= 1'b0;
      eot_r       <= 1'b0;
      busy_r      <= 1'b0;
      oe_std_r    <= 1'b0;
`ifdef SPI_SLV_QUAD_EN
      oe_quad_r   <= 1'b0;
`endif
    end else begin
      tx_ready_r <= 1'b0;
      eot_r      <= 1'b0;
      busy_r     <= ~csn_s;
      if (rx_valid_r && bus.rx_ready) rx_valid_r <= 1'b0;

      if (csn_rise) begin
        // End of transfer: partial words are abandoned, a pending rx word survives
        state_r     <= IDLE;
        eot_r       <= 1'b1;
        bit_cnt_r   <= 5'd0;
        dummy_cnt_r <= 16'd0;
        armed_r     <= 1'b0;
        oe_std_r    <= 1'b0;
`ifdef SPI_SLV_QUAD_EN
        oe_quad_r   <= 1'b0;
`endif
      end else if (csn_fall) begin
        // csn_fall outranks a coincident sclk_rise: that edge is not sampled
        state_r     <= CMD;
        cmd_r       <= 8'h00;
        ovf_r       <= 1'b0;
        udf_r       <= 1'b0;
        shift_r     <= 32'h0000_0000;
        bit_cnt_r   <= 5'd0;
        dummy_cnt_r <= 16'd0;
        armed_r     <= 1'b0;
        oe_std_r    <= 1'b0;
`ifdef SPI_SLV_QUAD_EN
        oe_quad_r   <= 1'b0;
`endif
      end else begin
        case (state_r)
          CMD: begin
            if (sclk_rise) begin
              shift_r <= rx_word_std;
              if (bit_cnt_r == 5'd7) begin
                bit_cnt_r   <= 5'd0;
                dummy_cnt_r <= 16'd0;
                armed_r     <= 1'b0;
                cmd_r       <= rx_word_std[7:0];
                case (rx_word_std[7:0])
                  8'h02: state_r <= WR_STD;
                  8'h0B: begin
                    if (DUMMY_CYCLES == 0) begin
                      state_r  <= RD_STD;
                      shift_r  <= tx_word;
                      oe_std_r <= 1'b1;
                      if (bus.tx_valid) tx_ready_r <= 1'b1;
                      else              udf_r      <= 1'b1;
                    end else begin
                      state_r <= DUMMY;
                    end
                  end
                  8'h9F: begin
                    state_r  <= RD_ID;
                    shift_r  <= ID_VALUE;
                    oe_std_r <= 1'b1;
                  end
`ifdef SPI_SLV_QUAD_EN
                  8'h32: state_r <= WR_QUAD;
                  8'h6B: begin
                    if (DUMMY_CYCLES == 0) begin
                      state_r   <= RD_QUAD;
                      shift_r   <= tx_word;
                      oe_quad_r <= 1'b1;
                      if (bus.tx_valid) tx_ready_r <= 1'b1;
                      else              udf_r      <= 1'b1;
                    end else begin
                      state_r <= DUMMY;
                    end
                  end
`endif
                  default: state_r <= IGNORE;
                endcase
              end else begin
                bit_cnt_r <= bit_cnt_r + 5'd1;
              end
            end
          end

          WR_STD: begin
            if (sclk_rise) begin
              shift_r <= rx_word_std;
              if (bit_cnt_r == 5'd31) begin
                bit_cnt_r <= 5'd0;
                if (rx_valid_r && !bus.rx_ready) begin
                  ovf_r <= 1'b1;
                end else begin
                  rx_hold_r  <= rx_word_std;
                  rx_valid_r <= 1'b1;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 5'd1;
              end
            end
          end

`ifdef SPI_SLV_QUAD_EN
          WR_QUAD: begin
            if (sclk_rise) begin
              shift_r <= rx_word_quad;
              if (bit_cnt_r == 5'd28) begin
                bit_cnt_r <= 5'd0;
                if (rx_valid_r && !bus.rx_ready) begin
                  ovf_r <= 1'b1;
                end else begin
                  rx_hold_r  <= rx_word_quad;
                  rx_valid_r <= 1'b1;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 5'd4;
              end
            end
          end
`endif

          DUMMY: begin
            if (sclk_rise) begin
              if (dummy_cnt_r == 16'(DUMMY_CYCLES - 1)) begin
                shift_r <= tx_word;
                if (bus.tx_valid) tx_ready_r <= 1'b1;
                else              udf_r      <= 1'b1;
`ifdef SPI_SLV_QUAD_EN
                if (cmd_r == 8'h6B) begin
                  state_r   <= RD_QUAD;
                  oe_quad_r <= 1'b1;
                end else begin
                  state_r   <= RD_STD;
                  oe_std_r  <= 1'b1;
                end
`else
                state_r  <= RD_STD;
                oe_std_r <= 1'b1;
`endif
              end else begin
                dummy_cnt_r <= dummy_cnt_r + 16'd1;
              end
            end
          end

          // Data advances only on a fall that follows a master sample, so the
          // bit presented at state entry is held through the first rising edge.
          RD_STD, RD_ID: begin
            if (sclk_rise) begin
              armed_r <= 1'b1;
            end else if (sclk_fall && armed_r) begin
              armed_r <= 1'b0;
              if (bit_cnt_r == 5'd31) begin
                bit_cnt_r <= 5'd0;
                if (state_r == RD_ID) begin
                  shift_r <= 32'h0000_0000;
                end else begin
                  shift_r <= tx_word;
                  if (bus.tx_valid) tx_ready_r <= 1'b1;
                  else              udf_r      <= 1'b1;
                end
              end else begin
                shift_r   <= {shift_r[30:0], 1'b0};
                bit_cnt_r <= bit_cnt_r + 5'd1;
              end
            end
          end

`ifdef SPI_SLV_QUAD_EN
          RD_QUAD: begin
            if (sclk_rise) begin
              armed_r <= 1'b1;
            end else if (sclk_fall && armed_r) begin
              armed_r <= 1'b0;
              if (bit_cnt_r == 5'd28) begin
                bit_cnt_r <= 5'd0;
                shift_r   <= tx_word;
                if (bus.tx_valid) tx_ready_r <= 1'b1;
                else              udf_r      <= 1'b1;
              end else begin
                shift_r   <= {shift_r[27:0], 4'h0};
                bit_cnt_r <= bit_cnt_r + 5'd4;
              end
            end
          end
`endif

          default: begin
            // IDLE and IGNORE wait for chip-select edges only
            state_r <= state_r;
          end
        endcase
      end
    end
  end

  assign bus.rx_data  = rx_hold_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.tx_ready = tx_ready_r;
  assign bus.cmd_o    = cmd_r;
  assign bus.busy_o   = busy_r;
  assign bus.eot_o    = eot_r;
  assign bus.ovf_o    = ovf_r;
  assign bus.udf_o    = udf_r;

  // Each data pin is gated by its enable so an undriven lane always reads 0
`ifdef SPI_SLV_QUAD_EN
  assign bus.spi_oe0  = oe_quad_r;
  assign bus.spi_oe1  = oe_std_r | oe_quad_r;
  assign bus.spi_oe2  = oe_quad_r;
  assign bus.spi_oe3  = oe_quad_r;
  assign bus.spi_sdo0 = oe_quad_r & shift_r[28];
  assign bus.spi_sdo1 = (oe_std_r & shift_r[31]) | (oe_quad_r & shift_r[29]);
  assign bus.spi_sdo2 = oe_quad_r & shift_r[30];
  assign bus.spi_sdo3 = oe_quad_r & shift_r[31];
`else
  assign bus.spi_oe0  = 1'b0;
  assign bus.spi_oe1  = oe_std_r;
  assign bus.spi_oe2  = 1'b0;
  assign bus.spi_oe3  = 1'b0;
  assign bus.spi_sdo0 = 1'b0;
  assign bus.spi_sdo1 = oe_std_r & shift_r[31];
  assign bus.spi_sdo2 = 1'b0;
  assign bus.spi_sdo3 = 1'b0;
`endif

endmodule
